// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single-ported memory between the instruction
// fetch port and the load/store data port. Each access takes one IDLE
// (arbitrate) cycle and one ACCESS cycle. Contention is resolved round-robin.
// Misaligned or out-of-range addresses are acked with err=1 and never written.
module mem_port_arbiter #(
    parameter int NUM_OF_BYTES = 1024
) (
    input  logic        clk,
    input  logic        mem_reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_we,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_address,
    output logic        mem_write_en,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic        busy
);

    localparam logic [31:0] MAX_ADDR = 32'(NUM_OF_BYTES - 4);

    typedef enum logic {IDLE, ACCESS} state_t;
    typedef enum logic {OWN_IF, OWN_D} port_t;

    state_t      state;
    port_t       owner;
    port_t       last_served;

    logic        if_elig;
    logic        d_elig;
    logic [31:0] cur_addr;
    logic        err_now;
    logic        is_store;

    // Request eligibility (a port being acked this cycle is masked) and
    // decode of the current owner's access.
    always_comb begin
        if_elig  = if_req && !if_ack;
        d_elig   = d_req && !d_ack;
        cur_addr = (owner == OWN_D) ? d_addr : if_addr;
        err_now  = (cur_addr[1:0] != 2'b00) || (cur_addr > MAX_ADDR);
        is_store = (owner == OWN_D) && d_we;
    end

    // Memory-side drive: only active during ACCESS; writes suppressed on error
    // and combinationally blocked while reset is asserted.
    always_comb begin
        mem_address    = '0;
        mem_write_en   = 1'b0;
        mem_write_data = '0;
        if (state == ACCESS) begin
            mem_address    = cur_addr;
            mem_write_data = is_store ? d_wdata : '0;
            mem_write_en   = is_store && !err_now && !mem_reset;
        end
    end

    assign busy = (state == ACCESS);

    // Arbitration FSM with registered ack/err/rdata per port.
    always_ff @(posedge clk) begin
        if (mem_reset) begin
            state       <= IDLE;
            owner       <= OWN_IF;
            last_served <= OWN_D;
            if_ack      <= 1'b0;
            d_ack       <= 1'b0;
            if_err      <= 1'b0;
            d_err       <= 1'b0;
            if_rdata    <= '0;
            d_rdata     <= '0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_elig && d_elig) begin
                        owner <= (last_served == OWN_IF) ? OWN_D : OWN_IF;
                        state <= ACCESS;
                    end else if (if_elig) begin
                        owner <= OWN_IF;
                        state <= ACCESS;
                    end else if (d_elig) begin
                        owner <= OWN_D;
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (owner == OWN_IF) begin
                        if_ack   <= 1'b1;
                        if_err   <= err_now;
                        if_rdata <= err_now ? '0 : mem_read_data;
                    end else begin
                        d_ack    <= 1'b1;
                        d_err    <= err_now;
                        d_rdata  <= (err_now || d_we) ? '0 : mem_read_data;
                    end
                    last_served <= owner;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Two-master arbiter that shares the single-ported fast_memory between the CPU instruction-fetch port and the load/store data port. Each access is registered and sequenced through a small FSM, with round-robin fairness on contention. Misaligned and out-of-range accesses are rejected before they reach the memory. The block sits between the CPU core and the memory: its mem_* outputs drive the memory's address/write_en/write_data inputs, and mem_read_data is fed back from the memory's read_data.

Parameters:
NUM_OF_BYTES, 1024, size of the attached memory in bytes; legal word addresses are 0 .. NUM_OF_BYTES-4.

Ports:
clk  input  1  system clock; all state updates on posedge
mem_reset  input  1  synchronous, active-high reset
if_req  input  1  instruction-fetch request; level, held until if_ack
if_addr  input  32  fetch byte address; held stable while if_req=1
if_ack  output  1  one-cycle pulse: fetch completed
if_rdata  output  32  fetched word; valid when if_ack=1
if_err  output  1  fetch rejected; valid when if_ack=1
d_req  input  1  data request; level, held until d_ack
d_addr  input  32  data byte address; held stable while d_req=1
d_we  input  1  1 = store, 0 = load; held stable while d_req=1
d_wdata  input  32  store data; held stable while d_req=1
d_ack  output  1  one-cycle pulse: data access completed
d_rdata  output  32  load data; valid when d_ack=1
d_err  output  1  data access rejected; valid when d_ack=1
mem_address  output  32  to memory address
mem_write_en  output  1  to memory write_en
mem_write_data  output  32  to memory write_data
mem_read_data  input  32  from memory read_data (combinational)
busy  output  1  1 while in ACCESS state

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; owner=IF; last_served=D, so IF wins the first tie.
  - if_ack, d_ack, if_err, d_err = 0; if_rdata, d_rdata = 0; busy=0.
- mem_write_en is combinationally forced to 0 while mem_reset=1, so a write in flight during reset is never committed.
- FSM has two states, IDLE and ACCESS.
- IDLE:
  - mem_address=0, mem_write_en=0, mem_write_data=0.
  - Eligible requesters: if_req && !if_ack, and d_req && !d_ack. The port being acked this cycle is masked so its still-high req is not re-granted.
  - If exactly one requester is eligible, it becomes owner.
  - If both are eligible, the one that is not last_served becomes owner.
  - On a grant: latch owner, go to ACCESS. If none is eligible, stay in IDLE.
- ACCESS (exactly 1 cycle):
  - mem_address = owner's addr.
  - mem_write_data = d_wdata when owner=D && d_we, else 0.
  - err_now = (addr[1:0] != 0) || (addr > NUM_OF_BYTES-4), compared as 32-bit unsigned with no wrap.
  - mem_write_en = (owner=D) && d_we && !err_now && !mem_reset.
  - At posedge:
    - owner's ack <= 1.
    - owner's err <= err_now.
    - owner's rdata <= 0 if err_now or a store, else mem_read_data.
    - last_served <= owner; state <= IDLE.
- Ack, err and rdata are registered. ack is a single-cycle pulse and clears the next cycle. rdata and err hold their value until that port's next ack.
- The write commits on the same posedge at which ack is registered.
- Latency: request sampled in IDLE at cycle t → ACCESS at t+1 → ack high at t+2.
- Peak throughput is one access per 2 cycles.
- Under continuous demand from both ports, grants strictly alternate IF, D, IF, D, ...
- The IF port never writes: mem_write_en is 0 whenever owner=IF.
- Dropping req before ack is illegal. The FSM still completes the access that is already in ACCESS.
- Reset during ACCESS: no write, no ack; next cycle state=IDLE.

Test Plan:
- Reset with all reqs=0 → all acks/errs=0, rdata=0, busy=0, mem_write_en=0; IDLE holds with mem_address=0.
- if_req=1, if_addr=0x0, memory word 0 = 0xE3A00838 → cycle+1: busy=1, mem_address=0; cycle+2: if_ack=1, if_rdata=0xE3A00838, if_err=0; if_ack is low the following cycle.
- Store then load:
  - d_req, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF → d_ack, d_err=0, d_rdata=0.
  - Then load at 0x40 → d_rdata=0xDEADBEEF.
- if_req and d_req held high together from reset for 8 cycles → acks on alternate cycles in order IF, D, IF, D; no port is acked twice in a row.
- Store to d_addr=0x42, then store to 0x3FE, then load at 0x400 → each gives d_ack with d_err=1; mem_write_en stays 0 throughout; words at 0x40 and 0x3FC are unchanged.
- Store 0x12345678 to 0x80 with mem_reset asserted during the ACCESS cycle → no d_ack, state=IDLE next cycle; a later load of 0x80 returns its prior contents.
